// File: rtl/helix_control_assemble.sv
// ============================================================================
// helix_control_assemble
// ----------------------------------------------------------------------------
// Upstream framer for the HELIX control-packet decoder. It hunts the inbound
// 16-bit control word stream for the 0xC751 header, then collects the header
// plus three control words. It checks SOF (word1[15:12] == 4'hF) and
// EOF (word3[3:0] == 4'h8) and emits one 64-bit AXIS beat:
//    [15:0] header, [31:16] word1, [47:32] word2, [63:48] word3.
// Malformed or stalled frames are dropped and counted.
//
// Parameters:
//    TIMEOUT    idle cycles allowed between words inside a frame (0 = off)
//    ERR_WIDTH  width of the saturating error counter
//
// Ports:
//    aclk, aresetn      clock, asynchronous active-low reset
//    s_axis_*           inbound 16-bit word stream (tdata/tvalid/tready)
//    m_axis_*           outbound 64-bit packet beat (tdata/tvalid/tready/
//                       tkeep/tuser/tlast)
//    frame_count_o      frames emitted, wraps
//    err_count_o        framing errors plus timeouts, saturating
//    timeout_o          one-cycle pulse when a frame is aborted on timeout
//
// Optional feature (macro HELIX_ASSEMBLE_FORWARD_BAD_EN):
//    When defined, frames failing the SOF or EOF check are forwarded with
//    m_axis_tuser = 4'h1 instead of being dropped, so a monitor can capture
//    them. Header resyncs and timeouts still drop the frame. When undefined,
//    bad frames are dropped and m_axis_tuser is constant 4'h0.
// ============================================================================
module helix_control_assemble #(
    parameter logic [15:0] TIMEOUT   = 16'd1024,
    parameter int          ERR_WIDTH = 8
) (
    input  logic                 aclk,
    input  logic                 aresetn,
    input  logic [15:0]          s_axis_tdata,
    input  logic                 s_axis_tvalid,
    output logic                 s_axis_tready,
    output logic [63:0]          m_axis_tdata,
    output logic                 m_axis_tvalid,
    input  logic                 m_axis_tready,
    output logic [7:0]           m_axis_tkeep,
    output logic [3:0]           m_axis_tuser,
    output logic                 m_axis_tlast,
    output logic [15:0]          frame_count_o,
    output logic [ERR_WIDTH-1:0] err_count_o,
    output logic                 timeout_o
);

    localparam logic [15:0] HEADER       = 16'hC751;
    // Idle count value during the TIMEOUT-th consecutive idle cycle; the
    // abort happens on the edge that ends that cycle.
    localparam logic [15:0] TIMEOUT_LAST = TIMEOUT - 16'd1;

    typedef enum logic [2:0] {
        HUNT = 3'd0,
        W1   = 3'd1,
        W2   = 3'd2,
        W3   = 3'd3,
        EMIT = 3'd4
    } state_e;

    state_e                 state_q, state_d;

    logic [63:0]            data_q;
    logic                   tvalid_q;
    logic [15:0]            frameCount_q;
    logic [ERR_WIDTH-1:0]   errCount_q;
    logic                   timeout_q;
    logic [15:0]            idleCount_q, idleCount_d;

    logic                   accept;
    logic                   isHeader;
    logic                   sofOk;
    logic                   eofOk;
    logic                   inFrame;
    logic                   timeoutFire;
    logic                   goEmit;

    logic                   load0, load1, load2, load3;
    logic                   errInc;
    logic                   frameDone;

`ifdef HELIX_ASSEMBLE_FORWARD_BAD_EN
    logic                   markBad;
    logic                   clearHi;
    logic                   bad_q;
`endif

    // Input qualification. Ready depends only on state, so the handshake
    // below never loops back through combinational logic.
    assign s_axis_tready = (state_q != EMIT);
    assign accept        = s_axis_tvalid && s_axis_tready;
    assign isHeader      = (s_axis_tdata == HEADER);
    assign sofOk         = (s_axis_tdata[15:12] == 4'hF);
    assign eofOk         = (s_axis_tdata[3:0] == 4'h8);
    assign inFrame       = (state_q == W1) || (state_q == W2) || (state_q == W3);

    // An accepted word always beats a timeout landing in the same cycle.
    assign timeoutFire   = (TIMEOUT != 16'd0) && inFrame && !accept &&
                           (idleCount_q == TIMEOUT_LAST);

    assign goEmit        = (state_q != EMIT) && (state_d == EMIT);

    // State register.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q <= HUNT;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic. A header seen in W1 restarts the frame in place.
    always_comb begin
        state_d = state_q;
        case (state_q)
            HUNT: begin
                if (accept && isHeader) begin
                    state_d = W1;
                end
            end
            W1: begin
                if (timeoutFire) begin
                    state_d = HUNT;
                end else if (accept) begin
                    if (sofOk) begin
                        state_d = W2;
                    end else if (isHeader) begin
                        state_d = W1;
                    end else begin
`ifdef HELIX_ASSEMBLE_FORWARD_BAD_EN
                        state_d = EMIT;
`else
                        state_d = HUNT;
`endif
                    end
                end
            end
            W2: begin
                if (timeoutFire) begin
                    state_d = HUNT;
                end else if (accept) begin
                    state_d = W3;
                end
            end
            W3: begin
                if (timeoutFire) begin
                    state_d = HUNT;
                end else if (accept) begin
                    if (eofOk) begin
                        state_d = EMIT;
                    end else begin
`ifdef HELIX_ASSEMBLE_FORWARD_BAD_EN
                        state_d = EMIT;
`else
                        state_d = HUNT;
`endif
                    end
                end
            end
            EMIT: begin
                if (m_axis_tready) begin
                    state_d = HUNT;
                end
            end
            default: state_d = HUNT;
        endcase
    end

    // Output/action decode: which slot loads, and when errors or completed
    // frames are counted.
    always_comb begin
        load0     = 1'b0;
        load1     = 1'b0;
        load2     = 1'b0;
        load3     = 1'b0;
        errInc    = 1'b0;
        frameDone = 1'b0;
`ifdef HELIX_ASSEMBLE_FORWARD_BAD_EN
        markBad   = 1'b0;
        clearHi   = 1'b0;
`endif
        case (state_q)
            HUNT: begin
                load0 = accept && isHeader;
            end
            W1: begin
                if (accept) begin
                    if (sofOk) begin
                        load1 = 1'b1;
                    end else if (isHeader) begin
                        load0  = 1'b1;
                        errInc = 1'b1;
                    end else begin
                        errInc = 1'b1;
`ifdef HELIX_ASSEMBLE_FORWARD_BAD_EN
                        load1   = 1'b1;
                        clearHi = 1'b1;
                        markBad = 1'b1;
`endif
                    end
                end
            end
            W2: begin
                load2 = accept;
            end
            W3: begin
                if (accept) begin
                    load3 = 1'b1;
                    if (!eofOk) begin
                        errInc = 1'b1;
`ifdef HELIX_ASSEMBLE_FORWARD_BAD_EN
                        markBad = 1'b1;
`else
                        load3   = 1'b0;
`endif
                    end
                end
            end
            EMIT: begin
                frameDone = m_axis_tready;
            end
            default: ;
        endcase
        if (timeoutFire) begin
            errInc = 1'b1;
        end
    end

    // Idle counter: counts only wordless cycles while staying in W1..W3.
    always_comb begin
        idleCount_d = 16'd0;
        if (inFrame && !accept && (state_d == state_q)) begin
            idleCount_d = idleCount_q + 16'd1;
        end
    end

    // Datapath: packet slots, output valid, counters and timeout pulse.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            data_q       <= 64'd0;
            tvalid_q     <= 1'b0;
            frameCount_q <= 16'd0;
            errCount_q   <= '0;
            timeout_q    <= 1'b0;
            idleCount_q  <= 16'd0;
        end else begin
            if (load0) begin
                data_q[15:0] <= s_axis_tdata;
            end
            if (load1) begin
                data_q[31:16] <= s_axis_tdata;
            end
            if (load2) begin
                data_q[47:32] <= s_axis_tdata;
            end
            if (load3) begin
                data_q[63:48] <= s_axis_tdata;
            end
`ifdef HELIX_ASSEMBLE_FORWARD_BAD_EN
            // A frame forwarded from W1 never collected words 2 and 3.
            if (clearHi) begin
                data_q[63:32] <= 32'd0;
            end
`endif
            if (goEmit) begin
                tvalid_q <= 1'b1;
            end else if (frameDone) begin
                tvalid_q <= 1'b0;
            end
            if (frameDone) begin
                frameCount_q <= frameCount_q + 16'd1;
            end
            if (errInc && (errCount_q != {ERR_WIDTH{1'b1}})) begin
                errCount_q <= errCount_q + ERR_WIDTH'(1);
            end
            timeout_q   <= timeoutFire;
            idleCount_q <= idleCount_d;
        end
    end

`ifdef HELIX_ASSEMBLE_FORWARD_BAD_EN
    // Bad-frame flag is captured when the frame enters EMIT.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            bad_q <= 1'b0;
        end else if (goEmit) begin
            bad_q <= markBad;
        end
    end

    assign m_axis_tuser = bad_q ? 4'h1 : 4'h0;
`else
    assign m_axis_tuser = 4'h0;
`endif

    assign m_axis_tdata  = data_q;
    assign m_axis_tvalid = tvalid_q;
    assign m_axis_tkeep  = 8'hFF;
    assign m_axis_tlast  = 1'b1;
    assign frame_count_o = frameCount_q;
    assign err_count_o   = errCount_q;
    assign timeout_o     = timeout_q;

endmodule

// File: tb/tb_helix_control_assemble.sv
// ============================================================================
// tb_helix_control_assemble
// ----------------------------------------------------------------------------
// Self-checking bench for helix_control_assemble (TIMEOUT = 8). Each scenario
// task drives words, pushes the beats it expects onto a scoreboard queue and
// compares what the DUT emits against the popped entries.
// ============================================================================
module tb_helix_control_assemble;

    localparam logic [63:0] GOOD_BEAT = 64'h6788_1235_F406_C751;

    logic        aclk = 1'b0;
    logic        aresetn;
    logic [15:0] s_axis_tdata;
    logic        s_axis_tvalid;
    logic        s_axis_tready;
    logic [63:0] m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready;
    logic [7:0]  m_axis_tkeep;
    logic [3:0]  m_axis_tuser;
    logic        m_axis_tlast;
    logic [15:0] frame_count_o;
    logic [7:0]  err_count_o;
    logic        timeout_o;

    int compared   = 0;
    int mismatched = 0;
    int expErr     = 0;
    int expFrames  = 0;

    logic [63:0] expData[$];
    logic [3:0]  expUser[$];

    helix_control_assemble #(
        .TIMEOUT   (16'd8),
        .ERR_WIDTH (8)
    ) dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tkeep  (m_axis_tkeep),
        .m_axis_tuser  (m_axis_tuser),
        .m_axis_tlast  (m_axis_tlast),
        .frame_count_o (frame_count_o),
        .err_count_o   (err_count_o),
        .timeout_o     (timeout_o)
    );

    always #5 aclk = ~aclk;

    // Present one word and hold it until the DUT takes it (bounded).
    task automatic applyStimulus(input logic [15:0] word);
        bit taken;
        taken = 1'b0;
        s_axis_tdata  = word;
        s_axis_tvalid = 1'b1;
        for (int i = 0; i < 50 && !taken; i++) begin
            @(negedge aclk);
            taken = s_axis_tready;
            @(posedge aclk);
        end
        #1;
        s_axis_tvalid = 1'b0;
        compared++;
        if (!taken) begin
            mismatched++;
            $display("[TB] FAIL input_accept: word %h not accepted, required acceptance within 50 cycles", word);
        end
    endtask

    // Wait (bounded) for one output handshake and return what was seen.
    task automatic captureBeat(output logic [63:0] data, output logic [3:0] user,
                               output logic [7:0] keep, output logic last, output bit got);
        got  = 1'b0;
        data = '0;
        user = '0;
        keep = '0;
        last = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge aclk);
            if (m_axis_tvalid && m_axis_tready) begin
                data = m_axis_tdata;
                user = m_axis_tuser;
                keep = m_axis_tkeep;
                last = m_axis_tlast;
                got  = 1'b1;
            end
        end
        @(posedge aclk);
        #1;
    endtask

    // Count cycles with tvalid high over a window.
    task automatic countValid(input int cycles, output int seen);
        seen = 0;
        repeat (cycles) begin
            @(negedge aclk);
            if (m_axis_tvalid) seen++;
        end
        @(posedge aclk);
        #1;
    endtask

    task automatic sendGoodFrame();
        expData.push_back(GOOD_BEAT);
        expUser.push_back(4'h0);
        applyStimulus(16'hC751);
        applyStimulus(16'hF406);
        applyStimulus(16'h1235);
        applyStimulus(16'h6788);
    endtask

    // Pop the next scoreboard entry and compare a captured beat against it.
    task automatic scoreBeat(input string name);
        logic [63:0] d;
        logic [3:0]  u;
        logic [7:0]  k;
        logic        l;
        bit          got;
        logic [63:0] ed;
        logic [3:0]  eu;
        captureBeat(d, u, k, l, got);
        compared++;
        if (!got) begin
            mismatched++;
            $display("[TB] FAIL %s_beat: no output handshake, required one within 40 cycles", name);
        end else begin
            ed = expData.pop_front();
            eu = expUser.pop_front();
            expFrames++;
            compared++;
            if (d !== ed) begin
                mismatched++;
                $display("[TB] FAIL %s_tdata: got %h, required %h", name, d, ed);
            end
            compared++;
            if (u !== eu) begin
                mismatched++;
                $display("[TB] FAIL %s_tuser: got %h, required %h", name, u, eu);
            end
            compared++;
            if (k !== 8'hFF || l !== 1'b1) begin
                mismatched++;
                $display("[TB] FAIL %s_keep_last: got %h/%b, required ff/1", name, k, l);
            end
        end
    endtask

    task automatic test_reset();
        aresetn       = 1'b0;
        s_axis_tvalid = 1'b0;
        s_axis_tdata  = 16'h0000;
        m_axis_tready = 1'b0;
        repeat (3) @(posedge aclk);
        #1;
        compared++;
        if (m_axis_tvalid !== 1'b0 || m_axis_tdata !== 64'd0 || timeout_o !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL reset_outputs: tvalid %b tdata %h timeout %b, required 0/0/0",
                     m_axis_tvalid, m_axis_tdata, timeout_o);
        end
        compared++;
        if (frame_count_o !== 16'd0 || err_count_o !== 8'd0 || s_axis_tready !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL reset_counters: frames %0d err %0d s_tready %b, required 0/0/1",
                     frame_count_o, err_count_o, s_axis_tready);
        end
        aresetn = 1'b1;
        @(posedge aclk);
        #1;
    endtask

    task automatic test_good_frame();
        m_axis_tready = 1'b1;
        applyStimulus(16'h1234);
        sendGoodFrame();
        scoreBeat("good");
        compared++;
        if (frame_count_o !== 16'(expFrames) || err_count_o !== 8'(expErr)) begin
            mismatched++;
            $display("[TB] FAIL good_counts: frames %0d err %0d, required %0d/%0d",
                     frame_count_o, err_count_o, expFrames, expErr);
        end
    endtask

    task automatic test_backpressure();
        bit stable;
        m_axis_tready = 1'b0;
        sendGoodFrame();
        stable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge aclk);
            if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== GOOD_BEAT || s_axis_tready !== 1'b0)
                stable = 1'b0;
        end
        compared++;
        if (!stable) begin
            mismatched++;
            $display("[TB] FAIL backpressure_hold: tvalid %b tdata %h s_tready %b, required 1/%h/0",
                     m_axis_tvalid, m_axis_tdata, s_axis_tready, GOOD_BEAT);
        end
        @(posedge aclk);
        #1;
        m_axis_tready = 1'b1;
        scoreBeat("backpressure");
        compared++;
        if (s_axis_tready !== 1'b1 || m_axis_tvalid !== 1'b0 || frame_count_o !== 16'(expFrames)) begin
            mismatched++;
            $display("[TB] FAIL backpressure_after: s_tready %b tvalid %b frames %0d, required 1/0/%0d",
                     s_axis_tready, m_axis_tvalid, frame_count_o, expFrames);
        end
    endtask

    task automatic test_bad_sof();
        int seen;
        m_axis_tready = 1'b1;
        expErr++;
`ifdef HELIX_ASSEMBLE_FORWARD_BAD_EN
        expData.push_back(64'h0000_0000_3406_C751);
        expUser.push_back(4'h1);
        applyStimulus(16'hC751);
        applyStimulus(16'h3406);
        scoreBeat("bad_sof");
`else
        applyStimulus(16'hC751);
        applyStimulus(16'h3406);
        countValid(6, seen);
        compared++;
        if (seen != 0) begin
            mismatched++;
            $display("[TB] FAIL bad_sof_dropped: tvalid high %0d cycles, required 0", seen);
        end
`endif
        compared++;
        if (err_count_o !== 8'(expErr) || s_axis_tready !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL bad_sof_err: err %0d s_tready %b, required %0d/1",
                     err_count_o, s_axis_tready, expErr);
        end
        sendGoodFrame();
        scoreBeat("after_bad_sof");
    endtask

    task automatic test_bad_eof();
        int seen;
        m_axis_tready = 1'b1;
        expErr++;
`ifdef HELIX_ASSEMBLE_FORWARD_BAD_EN
        expData.push_back(64'h6789_1235_F406_C751);
        expUser.push_back(4'h1);
`endif
        applyStimulus(16'hC751);
        applyStimulus(16'hF406);
        applyStimulus(16'h1235);
        applyStimulus(16'h6789);
`ifdef HELIX_ASSEMBLE_FORWARD_BAD_EN
        scoreBeat("bad_eof");
`else
        countValid(6, seen);
        compared++;
        if (seen != 0) begin
            mismatched++;
            $display("[TB] FAIL bad_eof_dropped: tvalid high %0d cycles, required 0", seen);
        end
`endif
        compared++;
        if (err_count_o !== 8'(expErr) || frame_count_o !== 16'(expFrames)) begin
            mismatched++;
            $display("[TB] FAIL bad_eof_counts: err %0d frames %0d, required %0d/%0d",
                     err_count_o, frame_count_o, expErr, expFrames);
        end
    endtask

    task automatic test_resync();
        m_axis_tready = 1'b1;
        expErr++;
        applyStimulus(16'hC751);
        sendGoodFrame();
        scoreBeat("resync");
        compared++;
        if (err_count_o !== 8'(expErr)) begin
            mismatched++;
            $display("[TB] FAIL resync_err: err %0d, required %0d", err_count_o, expErr);
        end
    endtask

    task automatic test_timeout();
        int seen;
        m_axis_tready = 1'b1;
        applyStimulus(16'hC751);
        applyStimulus(16'hF406);
        for (int i = 1; i <= 9; i++) begin
            @(posedge aclk);
            #1;
            compared++;
            if (timeout_o !== (i == 8)) begin
                mismatched++;
                $display("[TB] FAIL timeout_pulse_cycle%0d: timeout_o %b, required %b",
                         i, timeout_o, (i == 8));
            end
        end
        expErr++;
        compared++;
        if (err_count_o !== 8'(expErr)) begin
            mismatched++;
            $display("[TB] FAIL timeout_err: err %0d, required %0d", err_count_o, expErr);
        end
        // Back in HUNT, so the tail of the aborted frame is ignored.
        applyStimulus(16'h1235);
        applyStimulus(16'h6788);
        countValid(4, seen);
        compared++;
        if (seen != 0 || err_count_o !== 8'(expErr)) begin
            mismatched++;
            $display("[TB] FAIL timeout_hunt: tvalid cycles %0d err %0d, required 0/%0d",
                     seen, err_count_o, expErr);
        end
    endtask

    task automatic test_timeout_rescue();
        bit pulsed;
        pulsed = 1'b0;
        m_axis_tready = 1'b1;
        expData.push_back(GOOD_BEAT);
        expUser.push_back(4'h0);
        applyStimulus(16'hC751);
        applyStimulus(16'hF406);
        repeat (7) begin
            @(posedge aclk);
            #1;
            if (timeout_o) pulsed = 1'b1;
        end
        applyStimulus(16'h1235);
        if (timeout_o) pulsed = 1'b1;
        applyStimulus(16'h6788);
        if (timeout_o) pulsed = 1'b1;
        compared++;
        if (pulsed) begin
            mismatched++;
            $display("[TB] FAIL rescue_no_timeout: timeout_o pulsed, required no pulse");
        end
        scoreBeat("rescue");
        compared++;
        if (err_count_o !== 8'(expErr)) begin
            mismatched++;
            $display("[TB] FAIL rescue_err: err %0d, required %0d", err_count_o, expErr);
        end
    endtask

    task automatic test_back_to_back();
        m_axis_tready = 1'b1;
        expData.push_back(64'h0008_0000_F001_C751);
        expUser.push_back(4'h0);
        expData.push_back(64'h5678_1234_FABC_C751);
        expUser.push_back(4'h0);
        fork
            begin
                applyStimulus(16'hC751);
                applyStimulus(16'hF001);
                applyStimulus(16'h0000);
                applyStimulus(16'h0008);
                applyStimulus(16'hC751);
                applyStimulus(16'hFABC);
                applyStimulus(16'h1234);
                applyStimulus(16'h5678);
            end
            begin
                scoreBeat("b2b_first");
                scoreBeat("b2b_second");
            end
        join
        compared++;
        if (frame_count_o !== 16'(expFrames)) begin
            mismatched++;
            $display("[TB] FAIL b2b_frames: frames %0d, required %0d", frame_count_o, expFrames);
        end
    endtask

    task automatic test_reset_midframe();
        int seen;
        m_axis_tready = 1'b1;
        applyStimulus(16'hC751);
        applyStimulus(16'hF406);
        aresetn = 1'b0;
        #1;
        compared++;
        if (m_axis_tvalid !== 1'b0 || m_axis_tdata !== 64'd0 || frame_count_o !== 16'd0 ||
            err_count_o !== 8'd0 || timeout_o !== 1'b0 || s_axis_tready !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL midframe_reset_values: tvalid %b tdata %h frames %0d err %0d timeout %b s_tready %b, required 0/0/0/0/0/1",
                     m_axis_tvalid, m_axis_tdata, frame_count_o, err_count_o, timeout_o, s_axis_tready);
        end
        @(posedge aclk);
        #1;
        aresetn   = 1'b1;
        expErr    = 0;
        expFrames = 0;
        expData.delete();
        expUser.delete();
        applyStimulus(16'h1235);
        applyStimulus(16'h6788);
        countValid(6, seen);
        compared++;
        if (seen != 0 || frame_count_o !== 16'd0) begin
            mismatched++;
            $display("[TB] FAIL midframe_no_beat: tvalid cycles %0d frames %0d, required 0/0",
                     seen, frame_count_o);
        end
    endtask

    task automatic test_reset_in_emit();
        m_axis_tready = 1'b0;
        applyStimulus(16'hC751);
        applyStimulus(16'hF406);
        applyStimulus(16'h1235);
        applyStimulus(16'h6788);
        compared++;
        if (m_axis_tvalid !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL emit_before_reset: tvalid %b, required 1", m_axis_tvalid);
        end
        aresetn = 1'b0;
        #1;
        compared++;
        if (m_axis_tvalid !== 1'b0 || frame_count_o !== 16'd0) begin
            mismatched++;
            $display("[TB] FAIL emit_reset: tvalid %b frames %0d, required 0/0",
                     m_axis_tvalid, frame_count_o);
        end
        @(posedge aclk);
        #1;
        aresetn       = 1'b1;
        m_axis_tready = 1'b1;
        sendGoodFrame();
        scoreBeat("after_emit_reset");
        compared++;
        if (frame_count_o !== 16'd1 || err_count_o !== 8'd0) begin
            mismatched++;
            $display("[TB] FAIL after_emit_reset_counts: frames %0d err %0d, required 1/0",
                     frame_count_o, err_count_o);
        end
    endtask

    initial begin
        $display("[TB] helix_control_assemble bench start");
        test_reset();
        test_good_frame();
        test_backpressure();
        test_bad_sof();
        test_resync();
        test_bad_eof();
        test_timeout();
        test_timeout_rescue();
        test_back_to_back();
        test_reset_midframe();
        test_reset_in_emit();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
